// File: rtl/alpha_blender_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alpha_blender_pkg
// Description : Shared types and widths for the alpha blender slice.
// Revision    : 1.0 - initial release
// ============================================================================
package alpha_blender_pkg;

   localparam int PIX_W = 19;   // frame-buffer index width (640x480 frame)
   localparam int CH_W  = 8;    // colour / alpha channel width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      WRITE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/alpha_blender_if.sv
`default_nettype none
// ============================================================================
// Module      : alpha_blender_if
// Description : Pixel source / frame-buffer bundle for the alpha blender.
//               master = pixel source + frame buffer, slave = blender.
// Revision    : 1.0 - initial release
// ============================================================================
interface alpha_blender_if;
   import alpha_blender_pkg::*;

   logic [PIX_W-1:0] pixel_number;
   logic             pixel_ready;
   logic [CH_W-1:0]  r;
   logic [CH_W-1:0]  g;
   logic [CH_W-1:0]  b;
   logic [CH_W-1:0]  a;
   logic [CH_W-1:0]  read_r;
   logic [CH_W-1:0]  read_g;
   logic [CH_W-1:0]  read_b;
   logic             frame_ready;
   logic             o_frame_ready;
   logic             read;
   logic             write;
   logic [CH_W-1:0]  write_r;
   logic [CH_W-1:0]  write_g;
   logic [CH_W-1:0]  write_b;
   logic [PIX_W-1:0] addr;          // captured pixel index for read/write

   modport master (
      output pixel_number, pixel_ready, r, g, b, a,
      output read_r, read_g, read_b, frame_ready,
      input  o_frame_ready, read, write, write_r, write_g, write_b, addr
   );

   modport slave (
      input  pixel_number, pixel_ready, r, g, b, a,
      input  read_r, read_g, read_b, frame_ready,
      output o_frame_ready, read, write, write_r, write_g, write_b, addr
   );

endinterface
`default_nettype wire

// File: rtl/alpha_channel_blend.sv
`default_nettype none
// ============================================================================
// Module      : alpha_channel_blend
// Description : Combinational single-channel blend:
//               out = (a*src + (255-a)*dst) >> 8, truncating.
// Revision    : 1.0 - initial release
// ============================================================================
module alpha_channel_blend
   import alpha_blender_pkg::*;
(
   input  wire logic [CH_W-1:0] i_alpha,
   input  wire logic [CH_W-1:0] i_src,
   input  wire logic [CH_W-1:0] i_dst,
   output logic      [CH_W-1:0] o_blend
);

   logic [2*CH_W-1:0] w_prod_src;
   logic [2*CH_W-1:0] w_prod_dst;
   logic [2*CH_W:0]   w_sum;

   // Weighted sum of source and destination; max 255*255 so the shifted
   // result always fits in one channel.
   always_comb begin
      w_prod_src = i_alpha * i_src;
      w_prod_dst = (8'd255 - i_alpha) * i_dst;
      w_sum      = {1'b0, w_prod_src} + {1'b0, w_prod_dst};
      o_blend    = CH_W'(w_sum >> CH_W);
   end

endmodule
`default_nettype wire

// File: rtl/alpha_blender.sv
`default_nettype none
// ============================================================================
// Module      : alpha_blender
// Description : Read-modify-write alpha blender. Captures a source pixel,
//               reads the destination from the frame buffer, blends the
//               three channels and writes the result back. End-of-frame
//               strobes are held until the pipeline has drained.
// Revision    : 1.0 - initial release
// ============================================================================
module alpha_blender
   import alpha_blender_pkg::*;
#(
   parameter int READ_LATENCY = 2        // 1..15
)(
   input wire logic        clk,
   input wire logic        reset,        // synchronous, active-low
   alpha_blender_if.slave  bus
);

   localparam logic [3:0] c_LAT_INIT = 4'(READ_LATENCY);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_cnt;
   logic [3:0]       w_cnt_nxt;
   logic             w_capture;
   logic             w_sample;
   logic             w_read_nxt;
   logic             w_write_nxt;
   logic             w_ofr_nxt;

   logic             r_pending;
   logic             r_read;
   logic             r_write;
   logic             r_ofr;
   logic [PIX_W-1:0] r_addr;
   logic [CH_W-1:0]  r_alpha;
   logic [CH_W-1:0]  r_src   [3];
   logic [CH_W-1:0]  r_dst   [3];
   logic [CH_W-1:0]  r_out   [3];
   logic [CH_W-1:0]  w_blend [3];

   // State and wait-counter registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic and next values of the registered strobes
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      w_sample    = 1'b0;
      w_read_nxt  = 1'b0;
      w_write_nxt = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.pixel_ready) begin
               w_capture   = 1'b1;
               w_read_nxt  = 1'b1;
               w_cnt_nxt   = c_LAT_INIT;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
            // A zero count can only follow a corrupted state; treat as done.
            if (r_cnt <= 4'd1) begin
               w_sample    = 1'b1;
               w_state_nxt = WRITE;
            end
         end
         WRITE: begin
            w_write_nxt = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      // The end-of-frame strobe is released only once the blender is idle.
      w_ofr_nxt = r_pending && (r_state == IDLE);
   end

   // Strobe outputs and end-of-frame pending flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_read    <= 1'b0;
         r_write   <= 1'b0;
         r_ofr     <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         r_read    <= w_read_nxt;
         r_write   <= w_write_nxt;
         r_ofr     <= w_ofr_nxt;
         // A new strobe arriving as the old one is released stays pending.
         r_pending <= bus.frame_ready | (r_pending & ~w_ofr_nxt);
      end
   end

   // Pixel capture, destination sampling and result registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_addr  <= '0;
         r_alpha <= '0;
         for (int i = 0; i < 3; i++) begin
            r_src[i] <= '0;
            r_dst[i] <= '0;
            r_out[i] <= '0;
         end
      end else begin
         if (w_capture) begin
            r_addr   <= bus.pixel_number;
            r_alpha  <= bus.a;
            r_src[0] <= bus.r;
            r_src[1] <= bus.g;
            r_src[2] <= bus.b;
         end
         if (w_sample) begin
            r_dst[0] <= bus.read_r;
            r_dst[1] <= bus.read_g;
            r_dst[2] <= bus.read_b;
         end
         if (w_write_nxt) begin
            for (int i = 0; i < 3; i++) begin
               r_out[i] <= w_blend[i];
            end
         end
      end
   end

   generate
      for (genvar i = 0; i < 3; i++) begin : g_ch
         alpha_channel_blend u_blend (
            .i_alpha (r_alpha),
            .i_src   (r_src[i]),
            .i_dst   (r_dst[i]),
            .o_blend (w_blend[i])
         );
      end
   endgenerate

   assign bus.read          = r_read;
   assign bus.write         = r_write;
   assign bus.o_frame_ready = r_ofr;
   assign bus.write_r       = r_out[0];
   assign bus.write_g       = r_out[1];
   assign bus.write_b       = r_out[2];
   assign bus.addr          = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_alpha_blender.sv
`default_nettype none
// ============================================================================
// Module      : tb_alpha_blender
// Description : Self-checking bench for alpha_blender: table of blend
//               vectors through a write scoreboard, plus directed sequences
//               for end-of-frame, reset abort and ignored strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alpha_blender;

   localparam int LAT = 2;

   typedef struct {
      int pix;
      int r, g, b, a;
      int rr, rg, rb;
      int er, eg, eb;
   } vec_t;

   typedef struct {
      int pix;
      int er, eg, eb;
      int acc;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   rd_cnt  = 0;
   int   wr_cnt  = 0;
   int   ofr_cnt = 0;
   int   wr_cyc  = 0;
   int   ofr_cyc = 0;
   exp_t exp_q[$];
   vec_t vecs[6];

   alpha_blender_if bus ();

   alpha_blender #(.READ_LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Output monitor: counts strobes and scores every write against the queue
   always @(negedge clk) begin
      if (bus.read) rd_cnt++;
      if (bus.o_frame_ready) begin
         ofr_cnt++;
         ofr_cyc = cyc;
      end
      if (bus.write) begin
         wr_cnt++;
         wr_cyc = cyc;
         if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("write_r", int'(bus.write_r), e.er);
            check("write_g", int'(bus.write_g), e.eg);
            check("write_b", int'(bus.write_b), e.eb);
            check("addr",    int'(bus.addr),    e.pix);
            check("latency", cyc - e.acc,       LAT + 1);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present a pixel for one edge; returns #1 after the accepting edge.
   task automatic start_pixel(input vec_t v, input bit with_frame);
      exp_t e;
      @(posedge clk); #1;
      bus.pixel_number = 19'(v.pix);
      bus.r  = 8'(v.r);  bus.g  = 8'(v.g);  bus.b  = 8'(v.b);  bus.a = 8'(v.a);
      bus.read_r = 8'(v.rr); bus.read_g = 8'(v.rg); bus.read_b = 8'(v.rb);
      bus.pixel_ready = 1'b1;
      bus.frame_ready = with_frame;
      @(posedge clk); #1;
      bus.pixel_ready = 1'b0;
      bus.frame_ready = 1'b0;
      check("read_pulse", int'(bus.read), 1);
      e.pix = v.pix; e.er = v.er; e.eg = v.eg; e.eb = v.eb; e.acc = cyc;
      exp_q.push_back(e);
   endtask

   initial begin
      int rd0, wr0, of0, fcyc;
      vec_t v2;

      vecs[0] = '{0,      128, 64, 192, 17,  1,   2,   3,   9,   6,   15};
      vecs[1] = '{1,      0,   0,  0,   0,   255, 170, 0,   254, 169, 0};
      vecs[2] = '{1234,   255, 0,  100, 255, 37,  200, 255, 254, 0,   99};
      vecs[3] = '{5000,   200, 10, 255, 128, 100, 250, 0,   149, 129, 127};
      vecs[4] = '{70000,  0,   50, 100, 200, 255, 60,  5,   54,  51,  79};
      vecs[5] = '{307199, 255, 255, 255, 1,  255, 255, 255, 254, 254, 254};

      bus.pixel_number = '0; bus.pixel_ready = 1'b0; bus.frame_ready = 1'b0;
      bus.r = '0; bus.g = '0; bus.b = '0; bus.a = '0;
      bus.read_r = '0; bus.read_g = '0; bus.read_b = '0;

      // Reset state, with a frame strobe during reset that must be dropped
      bus.frame_ready = 1'b1;
      idle(3);
      bus.frame_ready = 1'b0;
      check("rst_read",  int'(bus.read), 0);
      check("rst_write", int'(bus.write), 0);
      check("rst_ofr",   int'(bus.o_frame_ready), 0);
      check("rst_out",   int'({bus.write_r, bus.write_g, bus.write_b}), 0);
      reset = 1'b1;
      idle(4);
      check("rst_frame_dropped", ofr_cnt, 0);

      // Table-driven blend vectors
      for (int i = 0; i < 6; i++) begin
         start_pixel(vecs[i], 1'b0);
         idle(LAT + 3);
      end
      check("table_reads",  rd_cnt, 6);
      check("table_writes", wr_cnt, 6);

      // Frame strobe while idle: released on the following edge
      @(posedge clk); #1;
      bus.frame_ready = 1'b1;
      @(posedge clk); #1;
      fcyc = cyc;
      bus.frame_ready = 1'b0;
      of0 = ofr_cnt;
      idle(3);
      check("idle_ofr_count", ofr_cnt - of0, 1);
      check("idle_ofr_cycle", ofr_cyc, fcyc + 1);

      // Frame strobe during WAIT: released one cycle after the write
      of0 = ofr_cnt;
      start_pixel(vecs[3], 1'b0);
      bus.frame_ready = 1'b1;
      @(posedge clk); #1;
      bus.frame_ready = 1'b0;
      idle(LAT + 5);
      check("wait_ofr_count", ofr_cnt - of0, 1);
      check("wait_ofr_cycle", ofr_cyc, wr_cyc + 1);

      // Frame strobe coincident with an accepted pixel
      of0 = ofr_cnt;
      start_pixel(vecs[0], 1'b1);
      idle(LAT + 5);
      check("coin_ofr_count", ofr_cnt - of0, 1);
      check("coin_ofr_cycle", ofr_cyc, wr_cyc + 1);

      // Second strobe during WAIT is ignored
      rd0 = rd_cnt; wr0 = wr_cnt;
      start_pixel(vecs[2], 1'b0);
      v2 = vecs[4];
      bus.pixel_number = 19'(v2.pix);
      bus.r = 8'(v2.r); bus.g = 8'(v2.g); bus.b = 8'(v2.b); bus.a = 8'(v2.a);
      bus.pixel_ready = 1'b1;
      @(posedge clk); #1;
      bus.pixel_ready = 1'b0;
      idle(LAT + 5);
      check("ignore_reads",  rd_cnt - rd0, 1);
      check("ignore_writes", wr_cnt - wr0, 1);

      // Reset during WAIT aborts the pixel; frame strobe in reset dropped
      wr0 = wr_cnt; of0 = ofr_cnt;
      start_pixel(vecs[1], 1'b0);
      reset = 1'b0;
      bus.frame_ready = 1'b1;
      @(posedge clk); #1;
      check("abort_read",  int'(bus.read), 0);
      check("abort_write", int'(bus.write), 0);
      check("abort_ofr",   int'(bus.o_frame_ready), 0);
      check("abort_out",   int'({bus.write_r, bus.write_g, bus.write_b}), 0);
      check("abort_addr",  int'(bus.addr), 0);
      reset = 1'b1;
      bus.frame_ready = 1'b0;
      void'(exp_q.pop_back());
      idle(LAT + 5);
      check("abort_no_write", wr_cnt - wr0, 0);
      check("abort_no_ofr",   ofr_cnt - of0, 0);

      // Blender still functional after the abort
      start_pixel(vecs[5], 1'b0);
      idle(LAT + 4);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
